// File: rtl/cue_pkg.sv
// rtl/cue_pkg.sv - shared types, widths and direction tables for the cue controller
package cue_pkg;

    typedef enum logic [1:0] {
        S_WAIT_STOP = 2'd0,
        S_AIM       = 2'd1,
        S_CHARGE    = 2'd2,
        S_FIRE      = 2'd3
    } cue_state_t;

    localparam int ANGLE_W   = 5;
    localparam int DIR_SCALE = 64;

    // round(DIR_SCALE * cos/sin(2*pi*k/32)); index 8 points +Y (screen down)
    localparam logic signed [7:0] COS_LUT [32] = '{
         8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
         8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
        -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12,
         8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63
    };

    localparam logic signed [7:0] SIN_LUT [32] = '{
         8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63,
         8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
         8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
        -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12
    };

endpackage

// File: rtl/cue_direction_lut.sv
// rtl/cue_direction_lut.sv - combinational cue direction to signed unit vector lookup
module cue_direction_lut
    import cue_pkg::*;
(
    input  logic [ANGLE_W-1:0] angle_idx,
    output logic signed [7:0]  cos_val,
    output logic signed [7:0]  sin_val
);

    assign cos_val = COS_LUT[angle_idx];
    assign sin_val = SIN_LUT[angle_idx];

endmodule

// File: rtl/cue_strike_ctrl.sv
// rtl/cue_strike_ctrl.sv - cue aiming, power charging and strike pulse generation
module cue_strike_ctrl
    import cue_pkg::*;
#(
    parameter int ANGLE_STEPS = 32,
    parameter int INIT_ANGLE  = 0,
    parameter int MAX_POWER   = 63,
    parameter int POWER_STEP  = 1,
    parameter int POWER_DIV   = 8,
    parameter int STOP_FRAMES = 2
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                key_charge,
    input  logic                key_left,
    input  logic                key_right,
    input  logic signed [31:0]  ball_velocityX,
    input  logic signed [31:0]  ball_velocityY,
    input  logic                scored,
    output logic                strike,
    output logic signed [31:0]  strike_velocityX,
    output logic signed [31:0]  strike_velocityY,
    output logic [5:0]          power,
    output logic [ANGLE_W-1:0]  angle_idx,
    output logic                cue_visible
);

    localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(ANGLE_STEPS - 1);
    localparam logic [ANGLE_W-1:0] ONE_ANGLE  = ANGLE_W'(1);

    cue_state_t          r_state, w_state_next;
    logic [5:0]          r_power, w_power_next;
    logic [ANGLE_W-1:0]  r_angle, w_angle_next;
    logic [7:0]          r_stop_cnt, w_stop_next;
    logic signed [31:0]  r_vel_x, w_vel_x_next;
    logic signed [31:0]  r_vel_y, w_vel_y_next;

    logic signed [7:0]   w_cos, w_sin;
    logic [6:0]          w_power_sum;
    logic [5:0]          w_power_sat;
    logic [ANGLE_W-1:0]  w_angle_inc, w_angle_dec;
    logic [7:0]          w_stop_inc;
    logic                w_ball_still;
    logic signed [31:0]  w_mul_x, w_mul_y;

    cue_direction_lut u_dir_lut (
        .angle_idx (r_angle),
        .cos_val   (w_cos),
        .sin_val   (w_sin)
    );

    assign w_power_sum  = {1'b0, r_power} + 7'(POWER_STEP);
    assign w_power_sat  = (w_power_sum > 7'(MAX_POWER)) ? 6'(MAX_POWER) : w_power_sum[5:0];
    assign w_angle_inc  = (r_angle == LAST_ANGLE) ? '0 : r_angle + ONE_ANGLE;
    assign w_angle_dec  = (r_angle == '0) ? LAST_ANGLE : r_angle - ONE_ANGLE;
    assign w_stop_inc   = r_stop_cnt + 8'd1;
    assign w_ball_still = (ball_velocityX == 32'sd0) && (ball_velocityY == 32'sd0);

    // Signed division truncates toward zero, matching the ball mover's arithmetic
    assign w_mul_x = $signed({26'd0, r_power}) * 32'(w_cos);
    assign w_mul_y = $signed({26'd0, r_power}) * 32'(w_sin);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_WAIT_STOP;
            r_power    <= '0;
            r_angle    <= ANGLE_W'(INIT_ANGLE);
            r_stop_cnt <= '0;
            r_vel_x    <= '0;
            r_vel_y    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_power    <= w_power_next;
            r_angle    <= w_angle_next;
            r_stop_cnt <= w_stop_next;
            r_vel_x    <= w_vel_x_next;
            r_vel_y    <= w_vel_y_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_power_next = r_power;
        w_angle_next = r_angle;
        w_stop_next  = r_stop_cnt;
        w_vel_x_next = r_vel_x;
        w_vel_y_next = r_vel_y;

        if (scored) begin
            w_state_next = S_WAIT_STOP;
            w_power_next = '0;
            w_stop_next  = '0;
        end else begin
            case (r_state)
                S_WAIT_STOP: begin
                    if (startOfFrame) begin
                        if (!w_ball_still) begin
                            w_stop_next = '0;
                        end else if (w_stop_inc >= 8'(STOP_FRAMES)) begin
                            w_state_next = S_AIM;
                            w_stop_next  = '0;
                        end else begin
                            w_stop_next = w_stop_inc;
                        end
                    end
                end
                S_AIM: begin
                    if (startOfFrame) begin
                        if (key_left && !key_right) begin
                            w_angle_next = w_angle_dec;
                        end else if (key_right && !key_left) begin
                            w_angle_next = w_angle_inc;
                        end
                        if (key_charge) begin
                            w_state_next = S_CHARGE;
                            w_power_next = '0;
                        end
                    end
                end
                S_CHARGE: begin
                    if (startOfFrame) begin
                        if (key_charge) begin
                            w_power_next = w_power_sat;
                        end else if (r_power == '0) begin
                            w_state_next = S_AIM;
                        end else begin
                            w_state_next = S_FIRE;
                            w_vel_x_next = w_mul_x / POWER_DIV;
                            w_vel_y_next = w_mul_y / POWER_DIV;
                        end
                    end
                end
                S_FIRE: begin
                    w_state_next = S_WAIT_STOP;
                    w_power_next = '0;
                    w_stop_next  = '0;
                end
                default: begin
                    w_state_next = S_WAIT_STOP;
                end
            endcase
        end
    end

    // Decoded from state so an asynchronous reset drops the pulse at once
    assign strike           = (r_state == S_FIRE) && !scored;
    assign cue_visible      = (r_state == S_AIM) || (r_state == S_CHARGE);
    assign strike_velocityX = r_vel_x;
    assign strike_velocityY = r_vel_y;
    assign power            = r_power;
    assign angle_idx        = r_angle;

endmodule

// File: tb/tb_cue_strike_ctrl.sv
// tb/tb_cue_strike_ctrl.sv - self-checking bench for cue_strike_ctrl
module tb_cue_strike_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetN, startOfFrame, key_charge, key_left, key_right, scored;
    logic signed [31:0] ball_vx, ball_vy, strike_vx, strike_vy;
    logic               strike, cue_visible;
    logic [5:0]         power;
    logic [4:0]         angle_idx;

    cue_strike_ctrl dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .key_charge       (key_charge),
        .key_left         (key_left),
        .key_right        (key_right),
        .ball_velocityX   (ball_vx),
        .ball_velocityY   (ball_vy),
        .scored           (scored),
        .strike           (strike),
        .strike_velocityX (strike_vx),
        .strike_velocityY (strike_vy),
        .power            (power),
        .angle_idx        (angle_idx),
        .cue_visible      (cue_visible)
    );

    typedef struct {
        int right_n;
        int left_n;
        int charge_n;
        int exp_angle;
        int exp_power;
        int exp_vx;
        int exp_vy;
    } shot_t;

    typedef struct {
        int vx;
        int vy;
    } vel_t;

    vel_t  sb_q[$];
    shot_t shots[8];
    int    n_tests = 0;
    int    n_fail = 0;
    int    strikes_seen = 0;
    int    exp_strikes = 0;
    logic  prev_strike = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        cyc(3);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    always @(negedge clk) begin
        if (!resetN) begin
            prev_strike = 1'b0;
        end else begin
            if (strike) begin
                strikes_seen++;
                check("strike_back_to_back", int'(prev_strike), 0);
                check("strike_with_sof", int'(startOfFrame), 0);
                check("strike_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    vel_t e;
                    e = sb_q.pop_front();
                    check("strike_vx", strike_vx, e.vx);
                    check("strike_vy", strike_vy, e.vy);
                end
            end
            prev_strike = strike;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        shots[0] = '{0,  0, 10, 0,  10, 80,   0};
        shots[1] = '{8,  0, 70, 8,  63, 0,    504};
        shots[2] = '{0,  4, 10, 4,  10, 56,   56};
        shots[3] = '{12, 0, 63, 16, 63, -504, 0};
        shots[4] = '{8,  0, 20, 24, 20, 0,    -160};
        shots[5] = '{0,  4, 5,  20, 5,  -28,  -28};
        shots[6] = '{15, 0, 7,  3,  7,  46,   31};
        shots[7] = '{0,  4, 3,  31, 3,  23,   -4};

        resetN = 1'b0; startOfFrame = 1'b0; key_charge = 1'b0;
        key_left = 1'b0; key_right = 1'b0; scored = 1'b0;
        ball_vx = 0; ball_vy = 0;
        cyc(2);
        check("rst_strike", int'(strike), 0);
        check("rst_vx", strike_vx, 0);
        check("rst_vy", strike_vy, 0);
        check("rst_power", int'(power), 0);
        check("rst_angle", int'(angle_idx), 0);
        check("rst_cue_visible", int'(cue_visible), 0);
        resetN = 1'b1;
        cyc(1);

        // Moving ball resets the rest counter and delays aiming
        frame();
        check("stop1_cue", int'(cue_visible), 0);
        ball_vx = 5;
        frame();
        ball_vx = 0;
        frame();
        check("stop_cleared_cue", int'(cue_visible), 0);
        frame();
        check("aim_cue", int'(cue_visible), 1);
        check("aim_angle", int'(angle_idx), 0);

        for (int i = 0; i < 8; i++) begin
            key_right = 1'b1;
            frames(shots[i].right_n);
            key_right = 1'b0;
            key_left = 1'b1;
            frames(shots[i].left_n);
            key_left = 1'b0;
            check($sformatf("shot%0d_angle", i), int'(angle_idx), shots[i].exp_angle);
            key_charge = 1'b1;
            frame();
            frames(shots[i].charge_n);
            check($sformatf("shot%0d_power", i), int'(power), shots[i].exp_power);
            sb_q.push_back('{shots[i].exp_vx, shots[i].exp_vy});
            exp_strikes++;
            key_charge = 1'b0;
            frame();
            check($sformatf("shot%0d_strikes", i), strikes_seen, exp_strikes);
            check($sformatf("shot%0d_power_clr", i), int'(power), 0);
            check($sformatf("shot%0d_cue_off", i), int'(cue_visible), 0);
            check($sformatf("shot%0d_vx_held", i), strike_vx, shots[i].exp_vx);
            frames(2);
            check($sformatf("shot%0d_reaim", i), int'(cue_visible), 1);
        end

        key_left = 1'b1; key_right = 1'b1;
        frame();
        key_left = 1'b0; key_right = 1'b0;
        check("both_keys_angle", int'(angle_idx), 31);

        // Charge pressed and released with zero power returns to aiming
        key_charge = 1'b1;
        frame();
        check("quick_power", int'(power), 0);
        key_charge = 1'b0;
        frame();
        key_right = 1'b1;
        frame();
        key_right = 1'b0;
        check("quick_back_to_aim", int'(angle_idx), 0);
        check("quick_no_strike", strikes_seen, exp_strikes);

        key_right = 1'b1;
        frames(2);
        key_right = 1'b0;
        key_charge = 1'b1;
        frames(6);
        check("sc_charge_power", int'(power), 5);
        cyc(1);
        scored = 1'b1;
        cyc(1);
        scored = 1'b0;
        key_charge = 1'b0;
        check("sc_charge_power_clr", int'(power), 0);
        check("sc_charge_cue", int'(cue_visible), 0);
        check("sc_charge_angle", int'(angle_idx), 2);
        frames(2);
        check("sc_charge_reaim", int'(cue_visible), 1);

        key_charge = 1'b1;
        frames(5);
        check("sc_fire_power", int'(power), 4);
        key_charge = 1'b0;
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        scored = 1'b1;
        #1;
        check("sc_fire_strike", int'(strike), 0);
        cyc(1);
        scored = 1'b0;
        check("sc_fire_power_clr", int'(power), 0);
        check("sc_fire_cue", int'(cue_visible), 0);
        check("sc_fire_no_strike", strikes_seen, exp_strikes);
        frames(2);

        key_right = 1'b1;
        frame();
        key_right = 1'b0;
        key_charge = 1'b1;
        frames(4);
        check("rst_mid_power", int'(power), 3);
        #2;
        resetN = 1'b0;
        #1;
        check("rst_mid_strike", int'(strike), 0);
        check("rst_mid_power_clr", int'(power), 0);
        check("rst_mid_angle", int'(angle_idx), 0);
        check("rst_mid_cue", int'(cue_visible), 0);
        check("rst_mid_vx", strike_vx, 0);
        check("rst_mid_vy", strike_vy, 0);
        key_charge = 1'b0;
        cyc(2);
        resetN = 1'b1;
        cyc(1);

        frames(2);
        key_left = 1'b1;
        frame();
        key_left = 1'b0;
        check("left_wrap_angle", int'(angle_idx), 31);

        cyc(4);
        check("sb_drained", sb_q.size(), 0);
        check("total_strikes", strikes_seen, exp_strikes);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
